// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, NR read ports, scoreboard set port and status.
// Read handshake: re[i] is a one-cycle request with no back-pressure. rvalid[i] is high for exactly the cycle after an accepted request, with rdata/rbusy. Requests are dropped while init_done=0.
interface regfile_mp_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int NR = 2
);
    logic             init_done;
    logic             state_dbg;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [NR-1:0]    re;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata;
    logic [NR-1:0]    rvalid;
    logic [NR-1:0]    rbusy;
    logic             sb_set;
    logic [AW-1:0]    sb_addr;

    modport master (
        output we, waddr, wdata, re, raddr, sb_set, sb_addr,
        input  init_done, state_dbg, rdata, rvalid, rbusy
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, sb_set, sb_addr,
        output init_done, state_dbg, rdata, rvalid, rbusy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset zero sweep, per-register busy scoreboard and r0 hardwired to zero.
// Optional same-cycle write-to-read bypass is compiled in with `define REGFILE_BYPASS_EN.
module regfile_mp #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int NR    = 2
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [AW-1:0]    cnt;
    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] busy, busy_next;
    logic [AW-1:0]    ra      [NR];
    logic [DW-1:0]    rd_val  [NR];
    logic [NR-1:0]    rd_busy;
    logic             run, wr_en, sb_en;

    assign run           = (state == ST_RUN);
    assign wr_en         = run && bus.we && (bus.waddr != '0);
    assign sb_en         = run && bus.sb_set && (bus.sb_addr != '0);
    assign bus.init_done = run;
    assign bus.state_dbg = logic'(state);

    always_comb begin
        state_next = state;
        unique case (state)
            ST_INIT: if (cnt == AW'(DEPTH - 1)) state_next = ST_RUN;
            ST_RUN:  state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == ST_INIT) cnt <= cnt + 1'b1;
        end
    end

    // Storage has no reset of its own; the sweep zeroes one entry per INIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == ST_INIT) regs[cnt] <= '0;
            else if (wr_en)       regs[bus.waddr] <= bus.wdata;
        end
    end

    // A same-cycle set beats the writeback clear of the same register.
    always_comb begin
        busy_next = busy;
        if (wr_en) busy_next[bus.waddr]   = 1'b0;
        if (sb_en) busy_next[bus.sb_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy <= '0;
        else      busy <= busy_next;
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            ra[i]      = bus.raddr[i*AW +: AW];
            rd_val[i]  = regs[ra[i]];
            rd_busy[i] = busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (bus.waddr == ra[i])) begin
                rd_val[i]  = bus.wdata;
                rd_busy[i] = sb_en && (bus.sb_addr == ra[i]);
            end
`endif
            if (ra[i] == '0) begin
                rd_val[i]  = '0;
                rd_busy[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.rdata  <= '0;
            bus.rvalid <= '0;
            bus.rbusy  <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (run && bus.re[i]) begin
                    bus.rdata[i*DW +: DW] <= rd_val[i];
                    bus.rvalid[i]         <= 1'b1;
                    bus.rbusy[i]          <= rd_busy[i];
                end else begin
                    bus.rvalid[i] <= 1'b0;
                end
            end
        end
    end
endmodule
